// File: rtl/extbus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : extbus_pkg
// Purpose  : Shared width, status-bit and address constants for extbus_responder.
// Revision : 1.0
// ============================================================================
package extbus_pkg;
  localparam int   EXTBUS_WIDTH = 16;
  localparam int   ST_NEMPTY    = 0;
  localparam int   ST_FULL      = 1;
  localparam int   ST_OVF       = 2;
  localparam logic A_DATA       = 1'b0;
  localparam logic A_STAT       = 1'b1;
endpackage
`default_nettype wire

// File: rtl/extbus_fifo.sv
`default_nettype none
// ============================================================================
// Module   : extbus_fifo
// Purpose  : Inbound FIFO, first-word-fall-through head, async active-low reset.
// Revision : 1.0
// ============================================================================
module extbus_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule
`default_nettype wire

// File: rtl/extbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : extbus_responder
// Purpose  : Board-side responder on the CPU's tri-state bus: inbound FIFO for
//            reads, outbound holding register for writes. Status port and ovf
//            clear exist only when EXTBUS_STATUS_EN is defined.
// Revision : 1.0
// ============================================================================
module extbus_responder
  import extbus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = EXTBUS_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             rw,
  input  logic             addr,
  inout  wire  [WIDTH-1:0] mem_cable,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);
  logic [WIDTH-1:0] head, rdata, data_word;
  logic             full, empty, is_stat;
  logic             rd_acc, wr_data, wr_stat, pop;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  assign data_word = empty ? '0 : head;

`ifdef EXTBUS_STATUS_EN
  logic [WIDTH-1:0] status;
  assign is_stat = (addr == A_STAT);
  always_comb begin
    status            = '0;
    status[ST_NEMPTY] = ~empty;
    status[ST_FULL]   = full;
    status[ST_OVF]    = ovf_q;
  end
  assign rdata   = is_stat ? status : data_word;
  assign wr_stat = sel & rw & is_stat & mem_cable[ST_OVF];
`else
  logic addr_unused;
  assign addr_unused = addr;
  assign is_stat     = 1'b0;
  assign rdata       = data_word;
  assign wr_stat     = 1'b0;
`endif

  assign rd_acc    = sel & ~rw;
  assign wr_data   = sel & rw & ~is_stat;
  assign pop       = rd_acc & ~is_stat;
  assign mem_cable = rd_acc ? rdata : 'z;

  extbus_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (in_valid),
    .din_i   (in_data),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // A data write always wins over the consumer handshake in the same cycle.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (wr_data) begin
      out_data_d  = mem_cable;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) ovf_d = 1'b1;
    end else begin
      if (wr_stat) ovf_d = 1'b0;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = ~full;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_extbus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_extbus_responder
// Purpose  : Directed bench for extbus_responder with a queue-based reference
//            model; adapts to EXTBUS_STATUS_EN.
// Revision : 1.0
// ============================================================================
module tb_extbus_responder;
  localparam int DEPTH = 4;
`ifdef EXTBUS_STATUS_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0, rw = 1'b0, addr = 1'b0;
  logic        cpu_oe = 1'b0;
  logic [15:0] cpu_dout = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, ovf;
  logic [15:0] out_data;
  wire  [15:0] mem_cable;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] m_out_data = '0;
  logic        m_out_valid = 1'b0;
  logic        m_ovf = 1'b0;

  assign mem_cable = cpu_oe ? cpu_dout : 'z;

  extbus_responder #(.DEPTH(DEPTH), .WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .rw        (rw),
    .addr      (addr),
    .mem_cable (mem_cable),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_rd();
    if (STAT_EN && addr)
      return {13'd0, m_ovf, mq.size() == DEPTH, mq.size() != 0};
    return (mq.size() != 0) ? mq[0] : 16'h0000;
  endfunction

  task automatic model_step();
    bit stat, pop, push;
    int n;
    if (!reset) begin
      mq.delete();
      m_out_data  = '0;
      m_out_valid = 1'b0;
      m_ovf       = 1'b0;
    end else begin
      n    = mq.size();
      stat = STAT_EN && addr;
      pop  = sel && !rw && !stat && n > 0;
      push = in_valid && n < DEPTH;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(in_data);
      if (sel && rw && !stat) begin
        if (m_out_valid && !out_ready) m_ovf = 1'b1;
        m_out_data  = mem_cable;
        m_out_valid = 1'b1;
      end else begin
        if (sel && rw && stat && mem_cable[2]) m_ovf = 1'b0;
        if (m_out_valid && out_ready) m_out_valid = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", 16'(in_ready), 16'(mq.size() < DEPTH));
    chk("out_valid", 16'(out_valid), 16'(m_out_valid));
    chk("out_data", out_data, m_out_data);
    chk("ovf", 16'(ovf), 16'(m_ovf));
    if (sel && !rw) chk("bus_read", mem_cable, exp_rd());
  end

  task automatic step(input logic s, input logic r, input logic a, input logic [15:0] d,
                      input logic iv, input logic [15:0] id, input logic ordy);
    @(posedge clk); #1;
    sel = s; rw = r; addr = a; cpu_dout = d; cpu_oe = s & r;
    in_valid = iv; in_data = id; out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy = 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, ordy);
  endtask

  task automatic rd(input logic a, input logic [15:0] exp, input string name);
    step(1'b1, 1'b0, a, 16'h0, 1'b0, 16'h0, 1'b0);
    chk(name, mem_cable, exp);
  endtask

  task automatic push(input logic [15:0] w);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, w, 1'b0);
  endtask

  task automatic wr(input logic a, input logic [15:0] d, input logic ordy);
    step(1'b1, 1'b1, a, d, 1'b0, 16'h0, ordy);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_ovf", 16'(ovf), 16'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Reset-state reads
`ifdef EXTBUS_STATUS_EN
    rd(1'b1, 16'h0000, "rst_status");
`endif
    rd(1'b0, 16'h0000, "rst_data");

    // Fill to full, then drain in order
    push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
    idle();
    chk("full_in_ready", 16'(in_ready), 16'h0);
`ifdef EXTBUS_STATUS_EN
    rd(1'b1, 16'h0003, "full_status");
`endif
    rd(1'b0, 16'hA001, "drain0");
    rd(1'b0, 16'hA002, "drain1");
    rd(1'b0, 16'hA003, "drain2");
    rd(1'b0, 16'hA004, "drain3");
    rd(1'b0, 16'h0000, "empty_read");
`ifdef EXTBUS_STATUS_EN
    rd(1'b1, 16'h0000, "empty_status");
`endif

    // Push and pop in the same cycle
    push(16'h1111); push(16'h2222);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h3333, 1'b0);
    chk("simul_read", mem_cable, 16'h1111);
`ifdef EXTBUS_STATUS_EN
    rd(1'b1, 16'h0001, "simul_status");
`endif
    rd(1'b0, 16'h2222, "simul_next0");
    rd(1'b0, 16'h3333, "simul_next1");
    rd(1'b0, 16'h0000, "simul_empty");

    // Pop from full: no push that cycle, slot frees next cycle
    push(16'hB001); push(16'hB002); push(16'hB003); push(16'hB004);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0);
    chk("fullpop_read", mem_cable, 16'hB001);
    chk("fullpop_rdy_same", 16'(in_ready), 16'h0);
    idle();
    chk("fullpop_rdy_next", 16'(in_ready), 16'h1);
    rd(1'b0, 16'hB002, "fullpop1");
    rd(1'b0, 16'hB003, "fullpop2");
    rd(1'b0, 16'hB004, "fullpop3");
    rd(1'b0, 16'h0000, "fullpop_empty");

    // Outbound handshake and overflow
    wr(1'b0, 16'h0041, 1'b0);
    idle();
    chk("wr1_valid", 16'(out_valid), 16'h1);
    chk("wr1_data", out_data, 16'h0041);
    chk("wr1_ovf", 16'(ovf), 16'h0);
    wr(1'b0, 16'h0043, 1'b0);
    idle();
    chk("wr2_data", out_data, 16'h0043);
    chk("wr2_ovf", 16'(ovf), 16'h1);
`ifdef EXTBUS_STATUS_EN
    rd(1'b1, 16'h0004, "ovf_status");
    wr(1'b1, 16'h0003, 1'b0);
    idle();
    chk("ovf_keep", 16'(ovf), 16'h1);
    wr(1'b1, 16'h0004, 1'b0);
    idle();
    chk("ovf_clear", 16'(ovf), 16'h0);
`endif
    idle(1'b1);
    idle();
    chk("consumed", 16'(out_valid), 16'h0);
    wr(1'b0, 16'h0055, 1'b0);
    wr(1'b0, 16'h0066, 1'b1);
    idle();
    chk("ready_wr_data", out_data, 16'h0066);
    chk("ready_wr_valid", 16'(out_valid), 16'h1);

    // Asynchronous reset mid-operation
    push(16'hC001); push(16'hC002); push(16'hC003);
    wr(1'b0, 16'h0077, 1'b0);
    idle();
    chk("pre_rst_valid", 16'(out_valid), 16'h1);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("mid_rst_in_ready", 16'(in_ready), 16'h1);
    chk("mid_rst_out_valid", 16'(out_valid), 16'h0);
    chk("mid_rst_out_data", out_data, 16'h0);
    chk("mid_rst_ovf", 16'(ovf), 16'h0);
    @(posedge clk); #1 reset = 1'b1;
    rd(1'b0, 16'h0000, "post_rst_data");
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
